pipe_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage pipeline. Detects load-use

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX hazard inputs, redirect request,
// and the stall/flush controls returned to the pipeline registers.
interface pipe_hazard_ctrl_if #(
  parameter int REG_WIDTH = 4,
  parameter int CNT_WIDTH = 16
);
  logic [REG_WIDTH-1:0] idSr1;
  logic [REG_WIDTH-1:0] idSr2;
  logic                 idUsesSr1;
  logic                 idUsesSr2;
  logic [REG_WIDTH-1:0] exDr;
  logic                 exMemtoReg;
  logic                 exRegWrite;
  logic                 exMulStart;
  logic                 redirect;
  logic                 pcWrite;
  logic                 ifIdWrite;
  logic                 idExBubble;
  logic                 ifIdFlush;
  logic                 idExFlush;
  logic                 exHold;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] stallCount;

  // Pipeline side: supplies hazard information, consumes the controls.
  modport master (
    output idSr1, idSr2, idUsesSr1, idUsesSr2, exDr, exMemtoReg, exRegWrite,
           exMulStart, redirect,
    input  pcWrite, ifIdWrite, idExBubble, ifIdFlush, idExFlush, exHold,
           state, stallCount
  );

  // Controller side.
  modport slave (
    input  idSr1, idSr2, idUsesSr1, idUsesSr2, exDr, exMemtoReg, exRegWrite,
           exMulStart, redirect,
    output pcWrite, ifIdWrite, idExBubble, ifIdFlush, idExFlush, exHold,
           state, stallCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// multi-cycle EX holds and wrong-path squashing after a redirect.
module pipe_hazard_ctrl #(
  parameter int REG_WIDTH    = 4,
  parameter int MUL_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [MCW-1:0] MUL_RELOAD   = (MUL_CYCLES > 1) ? MCW'(MUL_CYCLES - 2) : '0;
  localparam logic [FCW-1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? FCW'(FLUSH_CYCLES - 2) : '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [MCW-1:0]       mulCnt_q, mulCnt_d;
  logic [FCW-1:0]       flushCnt_q, flushCnt_d;
  logic [CNT_WIDTH-1:0] stallCount_q;
  logic                 loadUse;
  logic                 pcWrite;

  // A load in EX whose destination feeds the ID instruction; r0 never hazards.
  assign loadUse = hz.exMemtoReg && hz.exRegWrite && (hz.exDr != '0) &&
                   ((hz.idUsesSr1 && (hz.idSr1 == hz.exDr)) ||
                    (hz.idUsesSr2 && (hz.idSr2 == hz.exDr)));

  // Next-state and control outputs; priority redirect > multi-cycle > load-use.
  always_comb begin
    state_d        = state_q;
    mulCnt_d       = mulCnt_q;
    flushCnt_d     = flushCnt_q;
    pcWrite        = 1'b1;
    hz.ifIdWrite   = 1'b1;
    hz.idExBubble  = 1'b0;
    hz.ifIdFlush   = 1'b0;
    hz.idExFlush   = 1'b0;
    hz.exHold      = 1'b0;
    if (rst) begin
      state_d      = RUN;
      mulCnt_d     = '0;
      flushCnt_d   = '0;
      pcWrite      = 1'b0;
      hz.ifIdWrite = 1'b0;
      hz.ifIdFlush = 1'b1;
      hz.idExFlush = 1'b1;
    end else if (hz.redirect) begin
      hz.ifIdFlush = 1'b1;
      hz.idExFlush = 1'b1;
      mulCnt_d     = '0;
      if (FLUSH_CYCLES > 1) begin
        state_d    = REDIRECT;
        flushCnt_d = FLUSH_RELOAD;
      end else begin
        state_d    = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hz.exMulStart && (MUL_CYCLES > 1)) begin
            hz.exHold    = 1'b1;
            pcWrite      = 1'b0;
            hz.ifIdWrite = 1'b0;
            state_d      = MUL_WAIT;
            mulCnt_d     = MUL_RELOAD;
          end else if (loadUse) begin
            pcWrite       = 1'b0;
            hz.ifIdWrite  = 1'b0;
            hz.idExBubble = 1'b1;
          end
        end
        MUL_WAIT: begin
          if (mulCnt_q == '0) begin
            state_d = RUN;
          end else begin
            hz.exHold    = 1'b1;
            pcWrite      = 1'b0;
            hz.ifIdWrite = 1'b0;
            mulCnt_d     = mulCnt_q - 1'b1;
          end
        end
        REDIRECT: begin
          hz.ifIdFlush = 1'b1;
          hz.idExFlush = 1'b1;
          if (flushCnt_q == '0) begin
            state_d = RUN;
          end else begin
            flushCnt_d = flushCnt_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and sequencing counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      mulCnt_q   <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mulCnt_q   <= mulCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount_q <= '0;
    end else if (!pcWrite && (stallCount_q != '1)) begin
      stallCount_q <= stallCount_q + 1'b1;
    end
  end

  assign hz.pcWrite    = pcWrite;
  assign hz.state      = state_q;
  assign hz.stallCount = stallCount_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MUL_CYCLES=4,
// FLUSH_CYCLES=2, CNT_WIDTH=4 so saturation is reachable quickly).
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipe_hazard_ctrl_if #(.REG_WIDTH(4), .CNT_WIDTH(4)) bus ();

  pipe_hazard_ctrl #(
    .REG_WIDTH(4), .MUL_CYCLES(4), .FLUSH_CYCLES(2), .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] sr1, input logic [3:0] sr2,
                               input logic u1, input logic u2,
                               input logic [3:0] dr, input logic ld,
                               input logic rw, input logic mul,
                               input logic redir);
    bus.idSr1      = sr1;
    bus.idSr2      = sr2;
    bus.idUsesSr1  = u1;
    bus.idUsesSr2  = u2;
    bus.exDr       = dr;
    bus.exMemtoReg = ld;
    bus.exRegWrite = rw;
    bus.exMulStart = mul;
    bus.redirect   = redir;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {pcWrite, ifIdWrite, idExBubble, ifIdFlush, idExFlush, exHold}.
  function automatic logic [15:0] ctl();
    return {10'd0, bus.pcWrite, bus.ifIdWrite, bus.idExBubble,
            bus.ifIdFlush, bus.idExFlush, bus.exHold};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held for two cycles.
    tick();
    tick();
    checkOutput("rst_ctl", ctl(), 16'b00_0110);
    checkOutput("rst_state", {14'd0, bus.state}, 16'd0);
    checkOutput("rst_cnt", {12'd0, bus.stallCount}, 16'd0);
    rst = 1'b0;
    #2;
    checkOutput("idle_ctl", ctl(), 16'b11_0000);

    // Load-use through source 2.
    applyStimulus(4'd0, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("lu2_ctl", ctl(), 16'b00_1000);
    tick();
    applyStimulus(4'd0, 4'd5, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu2_cnt", {12'd0, bus.stallCount}, 16'd1);
    checkOutput("lu2_clear", ctl(), 16'b11_0000);

    // Register 0 never hazards.
    applyStimulus(4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("r0_ctl", ctl(), 16'b11_0000);
    tick();
    checkOutput("r0_cnt", {12'd0, bus.stallCount}, 16'd1);

    // Load-use through source 1; unused source 1 does not hazard.
    applyStimulus(4'd3, 4'd7, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("lu1_ctl", ctl(), 16'b00_1000);
    tick();
    applyStimulus(4'd3, 4'd7, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("lu1_unused", ctl(), 16'b11_0000);
    applyStimulus(4'd3, 4'd7, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_noregwr", ctl(), 16'b11_0000);
    tick();
    checkOutput("lu1_cnt", {12'd0, bus.stallCount}, 16'd2);

    // Multi-cycle op with a load-use pattern present: hold wins.
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("mul_t_ctl", ctl(), 16'b00_0001);
    tick();
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mul_t1_st", {14'd0, bus.state}, 16'd1);
    checkOutput("mul_t1_ctl", ctl(), 16'b00_0001);
    tick();
    checkOutput("mul_t2_st", {14'd0, bus.state}, 16'd1);
    checkOutput("mul_t2_ctl", ctl(), 16'b00_0001);
    tick();
    checkOutput("mul_t3_st", {14'd0, bus.state}, 16'd1);
    checkOutput("mul_t3_ctl", ctl(), 16'b11_0000);
    tick();
    checkOutput("mul_end_st", {14'd0, bus.state}, 16'd0);
    checkOutput("mul_cnt", {12'd0, bus.stallCount}, 16'd5);

    // Redirect during a multi-cycle hold.
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rd_t1_ctl", ctl(), 16'b11_0110);
    tick();
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_t2_st", {14'd0, bus.state}, 16'd2);
    checkOutput("rd_t2_ctl", ctl(), 16'b11_0110);
    tick();
    checkOutput("rd_t3_st", {14'd0, bus.state}, 16'd0);
    checkOutput("rd_t3_ctl", ctl(), 16'b11_0000);
    checkOutput("rd_cnt", {12'd0, bus.stallCount}, 16'd6);

    // Redirect and load-use together: redirect wins, no stall counted.
    applyStimulus(4'd9, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("rdlu_ctl", ctl(), 16'b11_0110);
    tick();
    applyStimulus(4'd9, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rdlu_cnt", {12'd0, bus.stallCount}, 16'd6);
    checkOutput("rdst_ignore", ctl(), 16'b11_0110);
    tick();
    applyStimulus(4'd9, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rdlu_back", {14'd0, bus.state}, 16'd0);
    checkOutput("rdlu_stall", ctl(), 16'b00_1000);

    // Twenty consecutive stall cycles saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat_cnt", {12'd0, bus.stallCount}, 16'hF);
    tick();
    checkOutput("sat_hold", {12'd0, bus.stallCount}, 16'hF);

    // Reset clears the counter.
    rst = 1'b1;
    #2;
    checkOutput("rst2_ctl", ctl(), 16'b00_0110);
    tick();
    checkOutput("rst2_cnt", {12'd0, bus.stallCount}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
